multicycle_main_control: RTL and testbench

- Main control FSM for the multicycle RV32I-subset datapath. Sits directly upstream of the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback. Drives datapath enables and mux selects, plus the 2-bit ALU_op consumed by the ALU control decoder.
- Handles variable-latency memory via a ready handshake with timeout.
- Maintains a retired-instruction counter.

---
 rtl/multicycle_main_control_pkg.sv | 39 +++
 rtl/multicycle_main_control_mem_wait_timer.sv | 19 +
 rtl/multicycle_main_control.sv | 127 ++++++++++++
 tb/tb_multicycle_main_control.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_main_control_pkg.sv
// multicycle_main_control_pkg: shared states, opcodes and datapath select encodings
package multicycle_main_control_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR,
    S_MEM_RD, S_MEM_WR, S_LOAD_WB, S_ALU_WB, S_BRANCH
  } state_e;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_instr;
    logic       bus_error;
  } ctrl_t;
  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH};
  endfunction
endpackage

// File: rtl/multicycle_main_control_mem_wait_timer.sv
// mem_wait_timer: counts stalled cycles of a memory access and flags the timeout cycle
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic ready_i,
  output logic timeout_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign timeout_o = active_i && !ready_i && cnt_q == W'(TIMEOUT_CYCLES - 1);
  // Any completion, timeout or non-waiting cycle restarts the count for the next access
  assign cnt_d = (!active_i || ready_i || timeout_o) ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: fetch/decode/execute/memory/writeback sequencer for the multicycle datapath
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PC_write,
  output logic             PC_write_cond,
  output logic             IorD,
  output logic             mem_read,
  output logic             mem_write,
  output logic             IR_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [1:0]       ALU_src_A,
  output logic [1:0]       ALU_src_B,
  output logic [1:0]       ALU_op,
  output logic             illegal_instr,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_count
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic wait_st, timeout, retire, unused_zero;
  ctrl_t ctl;
  // zero is consumed by the datapath's PC_write_cond gate, not by the sequencer
  assign unused_zero = zero;
  assign wait_st = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .active_i(wait_st),
    .ready_i(mem_ready),
    .timeout_o(timeout)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  state_d = opcode == OP_R ? S_EXEC_R :
                           opcode == OP_I ? S_EXEC_I :
                           opcode inside {OP_LOAD, OP_STORE} ? S_ADDR :
                           opcode == OP_BRANCH ? S_BRANCH : S_FETCH;
      S_EXEC_R:  state_d = S_ALU_WB;
      S_EXEC_I:  state_d = S_ALU_WB;
      S_ADDR:    state_d = opcode == OP_STORE ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  state_d = mem_ready ? S_LOAD_WB : timeout ? S_FETCH : S_MEM_RD;
      S_MEM_WR:  state_d = (mem_ready || timeout) ? S_FETCH : S_MEM_WR;
      default:   state_d = S_FETCH;
    endcase
  end
  assign retire = (state_q == S_MEM_WR && mem_ready) || state_q inside {S_LOAD_WB, S_ALU_WB, S_BRANCH};
  assign instr_count_d = instr_count_q + CNT_W'(retire);
  assign instr_count = instr_count_q;
  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_a = SRCA_PC;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALUOP_ADD;
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctl.alu_src_a = SRCA_OLDPC;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_RS2;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      S_ADDR: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
      end
      S_LOAD_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_ALU_WB: ctl.reg_write = 1'b1;
      S_BRANCH: begin
        ctl.alu_src_a     = SRCA_RS1;
        ctl.alu_src_b     = SRCB_RS2;
        ctl.alu_op        = ALUOP_SUB;
        ctl.pc_write_cond = 1'b1;
      end
      default: ;
    endcase
    ctl.illegal_instr = state_q == S_DECODE && !is_legal(opcode);
    ctl.bus_error     = timeout;
  end
  // Reset silences every control line at once so an abandoned instruction cannot write state
  assign {PC_write, PC_write_cond, IorD, mem_read, mem_write, IR_write, mem_to_reg, reg_write,
          ALU_src_A, ALU_src_B, ALU_op, illegal_instr, bus_error} = rst_n ? ctl : '0;
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: random and directed stimulus against a step-script reference model
module tb_multicycle_main_control;
  localparam int CW = 6;
  localparam int TO = 16;
  logic clk = 1'b0, rst_n, zero, mem_ready;
  logic [6:0] opcode;
  logic PC_write, PC_write_cond, IorD, mem_read, mem_write, IR_write, mem_to_reg, reg_write;
  logic [1:0] ALU_src_A, ALU_src_B, ALU_op;
  logic illegal_instr, bus_error;
  logic [CW-1:0] instr_count;
  logic [15:0] dut_cw;
  int checks = 0, errors = 0, pin_id = 0;
  bit m_fetch = 1'b1;
  multicycle_main_control #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PC_write(PC_write), .PC_write_cond(PC_write_cond), .IorD(IorD), .mem_read(mem_read),
    .mem_write(mem_write), .IR_write(IR_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .ALU_src_A(ALU_src_A), .ALU_src_B(ALU_src_B), .ALU_op(ALU_op),
    .illegal_instr(illegal_instr), .bus_error(bus_error), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  assign dut_cw = {PC_write, PC_write_cond, IorD, mem_read, mem_write, IR_write, mem_to_reg, reg_write,
                   ALU_src_A, ALU_src_B, ALU_op, illegal_instr, bus_error};
  typedef struct { logic [15:0] ctl; logic [15:0] rdy; bit mem; bit ret; bit dec; bit fetch; } step_t;
  // flags order: PC_write, PC_write_cond, IorD, mem_read, mem_write, IR_write, mem_to_reg, reg_write
  function automatic logic [15:0] cw(input logic [7:0] f, input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
    return {f, a, b, op, 2'b00};
  endfunction
  function automatic step_t mk(input logic [15:0] c, input bit mem, input bit ret);
    step_t s;
    s.ctl = c; s.rdy = '0; s.mem = mem; s.ret = ret; s.dec = 1'b0; s.fetch = 1'b0;
    return s;
  endfunction
  function automatic bit legal(input logic [6:0] o);
    return o == 7'h33 || o == 7'h13 || o == 7'h03 || o == 7'h23 || o == 7'h63;
  endfunction
  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 7'h33;
      1: return 7'h13;
      2: return 7'h03;
      3: return 7'h23;
      4: return 7'h63;
      default: return 7'($urandom);
    endcase
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  initial forever begin : cmp
    step_t sq[$];
    step_t s;
    int wcnt;
    logic [CW-1:0] mcount;
    logic [15:0] e;
    bit to;
    @(negedge clk);
    if (!rst_n) begin
      sq.delete();
      wcnt = 0;
      mcount = '0;
      chk("reset_ctl", 32'(dut_cw), 0);
      chk("reset_count", 32'(instr_count), 0);
      m_fetch = 1'b1;
    end else begin
      if (sq.size() == 0) begin
        s = mk(cw(8'b0001_0000, 2'b00, 2'b01, 2'b00), 1'b1, 1'b0);
        s.rdy = cw(8'b1000_0100, 2'b00, 2'b00, 2'b00);
        s.fetch = 1'b1;
        sq.push_back(s);
        s = mk(cw(8'b0, 2'b10, 2'b10, 2'b00), 1'b0, 1'b0);
        s.dec = 1'b1;
        sq.push_back(s);
      end
      s = sq[0];
      to = s.mem && !mem_ready && wcnt == TO - 1;
      e = s.ctl | ((s.mem && mem_ready) ? s.rdy : 16'h0) | (to ? 16'h0001 : 16'h0)
          | ((s.dec && !legal(opcode)) ? 16'h0002 : 16'h0);
      chk("ctl", 32'(dut_cw), 32'(e));
      chk("count", 32'(instr_count), 32'(mcount));
      if (s.mem && !mem_ready) begin
        if (to) begin
          sq.delete();
          wcnt = 0;
        end else wcnt++;
      end else begin
        void'(sq.pop_front());
        wcnt = 0;
        if (s.ret) mcount++;
        if (s.dec) begin
          if (opcode == 7'h33 || opcode == 7'h13) begin
            sq.push_back(mk(cw(8'b0, 2'b01, opcode == 7'h33 ? 2'b00 : 2'b10, 2'b10), 1'b0, 1'b0));
            sq.push_back(mk(cw(8'b0000_0001, 2'b00, 2'b00, 2'b00), 1'b0, 1'b1));
          end else if (opcode == 7'h03 || opcode == 7'h23) begin
            sq.push_back(mk(cw(8'b0, 2'b01, 2'b10, 2'b00), 1'b0, 1'b0));
            if (opcode == 7'h03) begin
              sq.push_back(mk(cw(8'b0011_0000, 2'b00, 2'b00, 2'b00), 1'b1, 1'b0));
              sq.push_back(mk(cw(8'b0000_0011, 2'b00, 2'b00, 2'b00), 1'b0, 1'b1));
            end else sq.push_back(mk(cw(8'b0010_1000, 2'b00, 2'b00, 2'b00), 1'b1, 1'b1));
          end else if (opcode == 7'h63)
            sq.push_back(mk(cw(8'b0100_0000, 2'b01, 2'b00, 2'b01), 1'b0, 1'b1));
        end
      end
      m_fetch = sq.size() == 0 || sq[0].fetch;
    end
    case (pin_id)
      1: begin chk("p_rst_mem_read", 32'(mem_read), 0); chk("p_rst_pcw", 32'(PC_write), 0); end
      2: begin chk("p_fetch_irw", 32'(IR_write), 1); chk("p_fetch_pcw", 32'(PC_write), 1); chk("p_fetch_srcb", 32'(ALU_src_B), 1); end
      3: begin chk("p_dec_srca", 32'(ALU_src_A), 2); chk("p_dec_srcb", 32'(ALU_src_B), 2); end
      4: begin chk("p_execr_op", 32'(ALU_op), 2); chk("p_execr_srca", 32'(ALU_src_A), 1); chk("p_execr_srcb", 32'(ALU_src_B), 0); end
      5: begin chk("p_aluwb_rw", 32'(reg_write), 1); chk("p_aluwb_m2r", 32'(mem_to_reg), 0); end
      6: begin chk("p_r_count", 32'(instr_count), 1); chk("p_stall_irw", 32'(IR_write), 0); end
      7: chk("p_ready_irw", 32'(IR_write), 1);
      8: begin chk("p_addr_op", 32'(ALU_op), 0); chk("p_addr_srcb", 32'(ALU_src_B), 2); end
      9: begin chk("p_memrd_rd", 32'(mem_read), 1); chk("p_memrd_iord", 32'(IorD), 1); end
      10: begin chk("p_ldwb_rw", 32'(reg_write), 1); chk("p_ldwb_m2r", 32'(mem_to_reg), 1); end
      11: chk("p_load_count", 32'(instr_count), 2);
      12: begin chk("p_br_pcc", 32'(PC_write_cond), 1); chk("p_br_op", 32'(ALU_op), 1); end
      13: chk("p_br_count", 32'(instr_count), 4);
      14: begin chk("p_ill_pulse", 32'(illegal_instr), 1); chk("p_ill_rw", 32'(reg_write), 0); end
      15: begin chk("p_ill_clear", 32'(illegal_instr), 0); chk("p_ill_count", 32'(instr_count), 4); end
      16: begin chk("p_to_early", 32'(bus_error), 0); chk("p_to_mw", 32'(mem_write), 1); end
      17: chk("p_to_pulse", 32'(bus_error), 1);
      18: begin chk("p_to_after", 32'(bus_error), 0); chk("p_to_mw_drop", 32'(mem_write), 0); chk("p_to_count", 32'(instr_count), 4); end
      19: begin chk("p_last_ready_be", 32'(bus_error), 0); chk("p_last_ready_mw", 32'(mem_write), 1); end
      20: chk("p_st_count", 32'(instr_count), 5);
      21: begin chk("p_arst_rd", 32'(mem_read), 0); chk("p_arst_iord", 32'(IorD), 0); chk("p_arst_count", 32'(instr_count), 0); end
      22: begin chk("p_rel_rd", 32'(mem_read), 1); chk("p_rel_count", 32'(instr_count), 0); end
      23: chk("p_wrap_max", 32'(instr_count), 63);
      24: chk("p_wrap_zero", 32'(instr_count), 0);
      default: ;
    endcase
  end
  task automatic step(input logic rdy, input int pin);
    mem_ready = rdy;
    pin_id = pin;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int p, len;
    rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = '0;
    @(posedge clk); #1;
    step(0, 1);
    rst_n = 1'b1;
    opcode = 7'h33;
    step(1, 2); step(0, 3); step(0, 4); step(0, 5);
    opcode = 7'h03;
    step(0, 6); step(0, 0); step(0, 0); step(1, 7);
    step(0, 0); step(0, 8); step(0, 9); step(0, 0); step(1, 0); step(0, 10);
    opcode = 7'h63; zero = 1'b1;
    step(1, 11); step(0, 0); step(0, 12);
    zero = 1'b0;
    step(1, 0); step(0, 0); step(0, 12);
    opcode = 7'h7f;
    step(1, 13); step(0, 14);
    opcode = 7'h23;
    step(1, 15); step(0, 0); step(0, 0);
    repeat (14) step(0, 0);
    step(0, 16); step(0, 17);
    step(1, 18); step(0, 0); step(0, 0);
    repeat (15) step(0, 0);
    step(1, 19);
    opcode = 7'h03;
    step(1, 20); step(0, 0); step(0, 0);
    mem_ready = 1'b0; pin_id = 21;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    step(0, 0);
    rst_n = 1'b1;
    opcode = 7'h63;
    step(1, 22); step(0, 0); step(0, 0);
    repeat (62) begin step(1, 0); step(0, 0); step(0, 0); end
    step(1, 23); step(0, 0); step(0, 0);
    step(1, 24);
    pin_id = 0;
    for (int seg = 0; seg < 60; seg++) begin
      case ($urandom_range(0, 3))
        0: p = 100;
        1: p = 60;
        2: p = 25;
        default: p = 0;
      endcase
      len = $urandom_range(10, 60);
      for (int k = 0; k < len; k++) begin
        if (m_fetch) opcode = rand_op();
        zero = 1'($urandom_range(0, 1));
        mem_ready = $urandom_range(0, 99) < p;
        if ($urandom_range(0, 299) == 0) begin
          #3 rst_n = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1;
        end
        @(posedge clk); #1;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
